// File: rtl/axi_sink_pkg.sv
// Shared types and constants for the AXI write-channel sink.
// Entry structs use the default ID width; modules with a different ID_W mirror them locally.
package axi_sink_pkg;

  localparam int DEFAULT_ID_W = 16;
  localparam int LEN_W        = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [DEFAULT_ID_W-1:0] id;
    logic [LEN_W-1:0]        len;
    logic [1:0]              resp;
  } aw_entry_t;

  typedef struct packed {
    logic [DEFAULT_ID_W-1:0] id;
    logic [1:0]              resp;
  } b_entry_t;

endpackage

// File: rtl/axi_sink_fifo.sv
// Generic synchronous FIFO with full/empty flags; push and pop may coincide.
// DEPTH must be a power of two, at least 2.
module axi_sink_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[PTR_W-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + (PTR_W+1)'(1);
    if (doPop)  rdPtr_d = rdPtr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axi_w_sink.sv
// AXI write-channel blackhole: accepts AW/W, discards data, answers one B per burst,
// flags misplaced wlast and keeps saturating transaction/beat counters.
module axi_w_sink
  import axi_sink_pkg::*;
#(
  parameter int ID_W            = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ID_W-1:0]  awid_i,
  input  logic [LEN_W-1:0] awlen_i,
  input  logic             awvalid_i,
  output logic             awready_o,
  input  logic             wlast_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [ID_W-1:0]  bid_o,
  output logic [1:0]       bresp_o,
  output logic             bvalid_o,
  input  logic             bready_i,
  input  logic [1:0]       cfg_bresp_i,
  output logic             err_wlast_o,
  output logic [CNT_W-1:0] txn_count_o,
  output logic [CNT_W-1:0] beat_count_o
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic [1:0]       resp;
  } awEntry_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } bEntry_t;

  awEntry_t         awPushData, awHead;
  bEntry_t          bPushData, bHead;
  logic             awFull, awEmpty, bFull, bEmpty;
  logic             awPush, awPop, bPush, bPop;
  logic             wFire, beatIsLast, beatErr;
  logic             active_q;
  logic [LEN_W-1:0] beatCnt_q, beatCnt_d;
  logic             burstErr_q, burstErr_d;
  logic             errWlast_q;
  logic [CNT_W-1:0] txnCount_q, beatCount_q;

  // active_q keeps awready low through reset and the edge that releases it.
  assign awready_o  = active_q && !awFull;
  assign awPush     = awvalid_i && awready_o;
  assign awPushData = '{id: awid_i, len: awlen_i, resp: cfg_bresp_i};

  assign wready_o   = active_q && !awEmpty && !bFull;
  assign wFire      = wvalid_i && wready_o;
  assign beatIsLast = (beatCnt_q == awHead.len);
  assign beatErr    = (wlast_i != beatIsLast);
  assign awPop      = wFire && beatIsLast;
  assign bPush      = awPop;
  assign bPushData  = '{id: awHead.id,
                        resp: (burstErr_q || beatErr) ? RESP_SLVERR : awHead.resp};

  assign bvalid_o   = !bEmpty;
  assign bid_o      = bEmpty ? '0 : bHead.id;
  assign bresp_o    = bEmpty ? '0 : bHead.resp;
  assign bPop       = bvalid_o && bready_i;

  assign err_wlast_o  = errWlast_q;
  assign txn_count_o  = txnCount_q;
  assign beat_count_o = beatCount_q;

  axi_sink_fifo #(
    .WIDTH ($bits(awEntry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) awQueue (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (awPush),
    .wdata_i (awPushData),
    .pop_i   (awPop),
    .rdata_o (awHead),
    .full_o  (awFull),
    .empty_o (awEmpty)
  );

  axi_sink_fifo #(
    .WIDTH ($bits(bEntry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) bQueue (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (bPush),
    .wdata_i (bPushData),
    .pop_i   (bPop),
    .rdata_o (bHead),
    .full_o  (bFull),
    .empty_o (bEmpty)
  );

  // The burst ends on the beat count alone; wlast only feeds the error flag.
  always_comb begin
    beatCnt_d  = beatCnt_q;
    burstErr_d = burstErr_q;
    if (wFire) begin
      if (beatIsLast) begin
        beatCnt_d  = '0;
        burstErr_d = 1'b0;
      end else begin
        beatCnt_d  = beatCnt_q + LEN_W'(1);
        burstErr_d = burstErr_q || beatErr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      active_q    <= 1'b0;
      beatCnt_q   <= '0;
      burstErr_q  <= 1'b0;
      errWlast_q  <= 1'b0;
      txnCount_q  <= '0;
      beatCount_q <= '0;
    end else begin
      active_q   <= 1'b1;
      beatCnt_q  <= beatCnt_d;
      burstErr_q <= burstErr_d;
      if (wFire && beatErr) errWlast_q <= 1'b1;
      if (wFire && (beatCount_q != '1)) beatCount_q <= beatCount_q + CNT_W'(1);
      if (bPop && (txnCount_q != '1)) txnCount_q <= txnCount_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_w_sink.sv
// Self-checking bench for axi_w_sink: directed scenarios followed by randomized bursts,
// with B responses predicted from the burst rules by a queue-based reference model.
module tb_axi_w_sink;

  typedef struct {
    logic [15:0] id;
    logic [7:0]  len;
    logic [1:0]  resp;
  } awTxn_t;

  typedef struct {
    logic [15:0] id;
    logic [1:0]  resp;
  } bTxn_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] awId = '0;
  logic [7:0]  awLen = '0;
  logic        awValid = 1'b0;
  logic        awReady;
  logic        wLast = 1'b0;
  logic        wValid = 1'b0;
  logic        wReady;
  logic [15:0] bId;
  logic [1:0]  bResp;
  logic        bValid;
  logic        bReady;
  logic        bReadyDir = 1'b1;
  logic        randBready = 1'b0;
  logic        randBit = 1'b0;
  logic [1:0]  cfgBresp = '0;
  logic        errWlast;
  logic [31:0] txnCount;
  logic [31:0] beatCount;

  int          checks = 0;
  int          errors = 0;
  int          beatModel = 0;
  int          txnModel = 0;
  logic        errModel = 1'b0;
  awTxn_t      awModelQ[$];
  bTxn_t       expQ[$];

  logic        stall = 1'b0;
  logic [15:0] prevId = '0;
  logic [1:0]  prevResp = '0;

  assign bReady = randBready ? randBit : bReadyDir;

  axi_w_sink dut (
    .clk          (clk),
    .rstn         (rstn),
    .awid_i       (awId),
    .awlen_i      (awLen),
    .awvalid_i    (awValid),
    .awready_o    (awReady),
    .wlast_i      (wLast),
    .wvalid_i     (wValid),
    .wready_o     (wReady),
    .bid_o        (bId),
    .bresp_o      (bResp),
    .bvalid_o     (bValid),
    .bready_i     (bReady),
    .cfg_bresp_i  (cfgBresp),
    .err_wlast_o  (errWlast),
    .txn_count_o  (txnCount),
    .beat_count_o (beatCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    randBit = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // B-channel monitor: ordering/content against the model and stability under backpressure.
  always @(negedge clk) begin
    if (!rstn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checkOutput("b_hold_valid", 64'(bValid), 64'(1));
        checkOutput("b_hold_id", 64'(bId), 64'(prevId));
        checkOutput("b_hold_resp", 64'(bResp), 64'(prevResp));
      end
      if (bValid && bReady) begin
        if (expQ.size() == 0) begin
          checkOutput("b_unexpected", 64'(bValid), 64'(0));
        end else begin
          bTxn_t e;
          e = expQ.pop_front();
          checkOutput("b_id", 64'(bId), 64'(e.id));
          checkOutput("b_resp", 64'(bResp), 64'(e.resp));
        end
      end
      stall    = bValid && !bReady;
      prevId   = bId;
      prevResp = bResp;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendAw(input logic [15:0] id, input logic [7:0] len, input logic [1:0] resp);
    int n = 0;
    awId = id; awLen = len; cfgBresp = resp; awValid = 1'b1;
    @(negedge clk);
    while (!awReady && n < 300) begin n++; @(negedge clk); end
    checkOutput("aw_accept", 64'(awReady), 64'(1));
    @(posedge clk); #1;
    awValid = 1'b0;
    awModelQ.push_back('{id: id, len: len, resp: resp});
  endtask

  task automatic oneBeat(input logic wl);
    int n = 0;
    wValid = 1'b1; wLast = wl;
    @(negedge clk);
    while (!wReady && n < 300) begin n++; @(negedge clk); end
    checkOutput("w_accept", 64'(wReady), 64'(1));
    @(posedge clk); #1;
    wValid = 1'b0; wLast = 1'b0;
    beatModel++;
  endtask

  // Drives the burst for the oldest accepted AW; badBeat < 0 means clean wlast placement.
  task automatic applyStimulus(input int badBeat);
    awTxn_t a;
    logic   err = 1'b0;
    a = awModelQ.pop_front();
    for (int i = 0; i <= int'(a.len); i++) begin
      if (i == badBeat) err = 1'b1;
      oneBeat((i == int'(a.len)) ^ (i == badBeat));
    end
    expQ.push_back('{id: a.id, resp: err ? 2'b10 : a.resp});
    txnModel++;
    if (err) errModel = 1'b1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 2000) begin n++; @(posedge clk); end
    checkOutput("b_drain", 64'(expQ.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_txn"}, 64'(txnCount), 64'(txnModel));
    checkOutput({tag, "_beat"}, 64'(beatCount), 64'(beatModel));
    checkOutput({tag, "_err"}, 64'(errWlast), 64'(errModel));
  endtask

  task automatic checkResetState();
    checkOutput("rst_awready", 64'(awReady), 64'(0));
    checkOutput("rst_wready", 64'(wReady), 64'(0));
    checkOutput("rst_bvalid", 64'(bValid), 64'(0));
    checkOutput("rst_bid", 64'(bId), 64'(0));
    checkOutput("rst_bresp", 64'(bResp), 64'(0));
    checkOutput("rst_err", 64'(errWlast), 64'(0));
    checkOutput("rst_txn", 64'(txnCount), 64'(0));
    checkOutput("rst_beat", 64'(beatCount), 64'(0));
  endtask

  initial begin
    // Reset and the first cycle after release.
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("awready_after_rst", 64'(awReady), 64'(1));

    // Single-beat burst.
    sendAw(16'h0012, 8'd0, 2'b00);
    applyStimulus(-1);
    waitDrain();
    checkCounters("single");

    // Eight-beat burst held under B backpressure for 20 cycles.
    bReadyDir = 1'b0;
    sendAw(16'h0003, 8'd7, 2'b00);
    applyStimulus(-1);
    repeat (20) begin
      @(negedge clk);
      checkOutput("bp_bvalid", 64'(bValid), 64'(1));
      checkOutput("bp_bid", 64'(bId), 64'(16'h0003));
    end
    @(posedge clk); #1;
    bReadyDir = 1'b1;
    waitDrain();
    checkCounters("backpressure");

    // Outstanding limit on AW, then on B.
    bReadyDir = 1'b0;
    for (int k = 0; k < 4; k++) sendAw(16'h0020 + 16'(k), 8'd1, 2'b00);
    @(negedge clk);
    checkOutput("aw_full_awready", 64'(awReady), 64'(0));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) applyStimulus(-1);
    sendAw(16'h0030, 8'd0, 2'b01);
    wValid = 1'b1; wLast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("b_full_wready", 64'(wReady), 64'(0));
    end
    @(posedge clk); #1;
    wValid = 1'b0; wLast = 1'b0;
    bReadyDir = 1'b1;
    applyStimulus(-1);
    waitDrain();
    checkCounters("outstanding");

    // Misplaced wlast, then a clean burst with a non-default response code.
    sendAw(16'h0005, 8'd3, 2'b00);
    applyStimulus(2);
    waitDrain();
    checkCounters("wlast_err");
    sendAw(16'h0006, 8'd0, 2'b01);
    applyStimulus(-1);
    waitDrain();
    checkCounters("after_err");

    // W presented before its AW.
    wValid = 1'b1; wLast = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("w_before_aw", 64'(wReady), 64'(0));
    end
    @(posedge clk); #1;
    awId = 16'h0044; awLen = 8'd0; cfgBresp = 2'b00; awValid = 1'b1;
    @(negedge clk);
    checkOutput("wba_awready", 64'(awReady), 64'(1));
    checkOutput("wba_wready_same_cycle", 64'(wReady), 64'(0));
    @(posedge clk); #1;
    awValid = 1'b0;
    @(negedge clk);
    checkOutput("wba_wready_next", 64'(wReady), 64'(1));
    @(posedge clk); #1;
    wValid = 1'b0; wLast = 1'b0;
    beatModel++; txnModel++;
    expQ.push_back('{id: 16'h0044, resp: 2'b00});
    waitDrain();
    checkCounters("w_before_aw");

    // Longest burst.
    sendAw(16'h0077, 8'd255, 2'b11);
    applyStimulus(-1);
    waitDrain();
    checkCounters("len255");

    // Reset in the middle of a burst.
    sendAw(16'h0055, 8'd3, 2'b00);
    awModelQ.delete();
    oneBeat(1'b0);
    oneBeat(1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    beatModel = 0; txnModel = 0; errModel = 1'b0; expQ.delete();
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("awready_after_midrst", 64'(awReady), 64'(1));
    repeat (5) begin
      @(negedge clk);
      checkOutput("no_b_after_rst", 64'(bValid), 64'(0));
    end
    @(posedge clk); #1;
    sendAw(16'h0056, 8'd3, 2'b00);
    applyStimulus(-1);
    waitDrain();
    checkCounters("after_midrst");

    // Randomized bursts with random B backpressure.
    randBready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      int nAw;
      int lens[3];
      nAw = int'($urandom_range(1, 3));
      for (int k = 0; k < nAw; k++) begin
        lens[k] = int'($urandom_range(0, 7));
        sendAw(16'($urandom), 8'(lens[k]), 2'($urandom));
      end
      cfgBresp = 2'($urandom);
      for (int k = 0; k < nAw; k++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(int'($urandom_range(0, lens[k])));
        else applyStimulus(-1);
      end
    end
    randBready = 1'b0;
    waitDrain();
    checkCounters("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
